// File: rtl/tri_bus_arbiter_pkg.sv
// Shared types and helpers for the round-robin tristate bus controller.
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        TURN  = 2'd2
    } state_e;

    // Index width for n items; never below one bit so degenerate sizes still elaborate.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: searches from the channel after `last`,
// so `last` itself only wins when nobody else is requesting.
module rr_arbiter
    import tri_bus_pkg::*;
#(
    parameter int CHANNELS = 4,
    localparam int OW = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [OW-1:0]       last,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [OW-1:0]       index
);

    logic found_s;
    int   cand_s;

    // First requester in rotating order after the previous owner.
    always_comb begin
        grant   = '0;
        index   = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= CHANNELS; k++) begin
            cand_s = (int'(last) + k) % CHANNELS;
            if (en && !found_s && req[cand_s]) begin
                grant[cand_s] = 1'b1;
                index         = OW'(cand_s);
                found_s       = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// Round-robin owner of a shared tristate bus with a one-cycle Z turnaround.
// Optional BUS_KEEPER_EN: bus_q holds the last driven value while the bus is released.
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 4,
    parameter int MAX_HOLD = 8,
    localparam int OW = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS-1:0]       req,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [CHANNELS-1:0]       gnt,
    output logic [OW-1:0]             owner,
    output logic                      busy,
    inout  wire  [WIDTH-1:0]          bus,
    output logic [WIDTH-1:0]          bus_q
);

    localparam int             HW        = idx_width(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    // Pretending the last owner was the top channel makes the first search start at 0.
    localparam logic [OW-1:0]  START_PTR = OW'(CHANNELS - 1);

    state_e                state_r;
    state_e                state_nxt_s;
    logic [CHANNELS-1:0]   gnt_r;
    logic [CHANNELS-1:0]   gnt_nxt_s;
    logic [CHANNELS-1:0]   arb_gnt_s;
    logic [OW-1:0]         owner_r;
    logic [OW-1:0]         owner_nxt_s;
    logic [OW-1:0]         arb_idx_s;
    logic [OW-1:0]         arb_last_s;
    logic                  busy_r;
    logic                  busy_nxt_s;
    logic                  started_r;
    logic                  started_nxt_s;
    logic                  arb_en_s;
    logic                  oe_s;
    logic [HW-1:0]         hold_cnt_r;
    logic [HW-1:0]         hold_nxt_s;
    logic [WIDTH-1:0]      drive_data_s;
    logic [WIDTH-1:0]      bus_q_r;

    assign arb_last_s = started_r ? owner_r : START_PTR;
    assign arb_en_s   = (state_r != DRIVE);

    rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
        .req   (req),
        .last  (arb_last_s),
        .en    (arb_en_s),
        .grant (arb_gnt_s),
        .index (arb_idx_s)
    );

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            owner_r    <= '0;
            busy_r     <= 1'b0;
            started_r  <= 1'b0;
            hold_cnt_r <= '0;
        end else begin
            state_r    <= state_nxt_s;
            gnt_r      <= gnt_nxt_s;
            owner_r    <= owner_nxt_s;
            busy_r     <= busy_nxt_s;
            started_r  <= started_nxt_s;
            hold_cnt_r <= hold_nxt_s;
        end
    end

    // Next-state decision.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (|req) state_nxt_s = DRIVE;
                else      state_nxt_s = IDLE;
            end
            DRIVE: begin
                if (!req[owner_r] || (hold_cnt_r == HOLD_LAST)) state_nxt_s = TURN;
                else                                             state_nxt_s = DRIVE;
            end
            TURN: begin
                if (|req) state_nxt_s = DRIVE;
                else      state_nxt_s = IDLE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Values the output registers take with the next state; a fresh grant only on DRIVE entry.
    always_comb begin
        gnt_nxt_s     = '0;
        busy_nxt_s    = 1'b0;
        owner_nxt_s   = owner_r;
        hold_nxt_s    = '0;
        started_nxt_s = started_r;
        case (state_nxt_s)
            DRIVE: begin
                busy_nxt_s = 1'b1;
                if (state_r == DRIVE) begin
                    gnt_nxt_s  = gnt_r;
                    hold_nxt_s = hold_cnt_r + HW'(1);
                end else begin
                    gnt_nxt_s     = arb_gnt_s;
                    owner_nxt_s   = arb_idx_s;
                    started_nxt_s = 1'b1;
                end
            end
            default: begin
                gnt_nxt_s  = '0;
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    assign oe_s         = (state_r == DRIVE);
    assign drive_data_s = din[owner_r*WIDTH +: WIDTH];
    assign bus          = oe_s ? drive_data_s : {WIDTH{1'bz}};

`ifdef BUS_KEEPER_EN
    // Read-back that freezes on the last driven value while the bus floats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q_r <= '0;
        end else if (oe_s) begin
            bus_q_r <= bus;
        end else begin
            bus_q_r <= bus_q_r;
        end
    end
`else
    // Read-back of whatever is on the bus each cycle, released or not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_q_r <= '0;
        end else begin
            bus_q_r <= bus;
        end
    end
`endif

    assign gnt   = gnt_r;
    assign owner = owner_r;
    assign busy  = busy_r;
    assign bus_q = bus_q_r;

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// Directed bench for tri_bus_arbiter (WIDTH=4, CHANNELS=4, MAX_HOLD=8).
module tb_tri_bus_arbiter;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int MAX_HOLD = 8;
    // The bus is pulled up, so a released bus reads as all ones.
    localparam logic [3:0] REL = 4'hF;
`ifdef BUS_KEEPER_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [15:0] din;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    wire  [3:0]  bus;
    logic [3:0]  bus_q;

    pullup (bus[0]);
    pullup (bus[1]);
    pullup (bus[2]);
    pullup (bus[3]);

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    tri_bus_arbiter #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .owner (owner),
        .busy  (busy),
        .bus   (bus),
        .bus_q (bus_q)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one cycle and check grant, busy and bus for that cycle.
    task automatic cyc(input string tag, input logic [3:0] g, input logic [3:0] b);
        @(posedge clk);
        #1;
        chk({tag, ".gnt"}, gnt, g);
        chk({tag, ".busy"}, {3'b000, busy}, {3'b000, |g});
        chk({tag, ".bus"}, bus, b);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        din   = {4'h3, 4'h2, 4'h1, 4'hA};
        #1;
        chk("rst.gnt", gnt, 4'b0000);
        chk("rst.busy", {3'b000, busy}, 4'h0);
        chk("rst.owner", {2'b00, owner}, 4'h0);
        chk("rst.bus", bus, REL);
        chk("rst.bus_q", bus_q, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("idle", 4'b0000, REL);

        // Single requester: grant one cycle after req, bus_q one cycle after bus.
        req = 4'b0001;
        cyc("t1.grant", 4'b0001, 4'hA);
        chk("t1.owner", {2'b00, owner}, 4'h0);
        cyc("t1.hold", 4'b0001, 4'hA);
        chk("t1.bus_q", bus_q, 4'hA);
        req = 4'b0000;
        cyc("t1.turn", 4'b0000, REL);
        chk("t1.turn_q", bus_q, 4'hA);
        cyc("t1.idle", 4'b0000, REL);
        chk("t1.idle_q", bus_q, KEEP ? 4'hA : REL);

        // Two continuous requesters alternate after MAX_HOLD cycles with one Z gap.
        req = 4'b0110;
        for (int i = 0; i < MAX_HOLD; i++) cyc("t2.own1", 4'b0010, 4'h1);
        cyc("t2.gap1", 4'b0000, REL);
        for (int i = 0; i < MAX_HOLD; i++) cyc("t2.own2", 4'b0100, 4'h2);
        cyc("t2.gap2", 4'b0000, REL);
        cyc("t2.own1b", 4'b0010, 4'h1);
        req = 4'b0000;
        cyc("t2.turn", 4'b0000, REL);
        cyc("t2.idle", 4'b0000, REL);

        // Lone requester re-wins after each turnaround: 8 drive, 1 Z, repeated.
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            if ((i % 9) == 8) cyc("t3.gap", 4'b0000, REL);
            else              cyc("t3.drive", 4'b1000, 4'h3);
        end
        req = 4'b0000;
        cyc("t3.turn", 4'b0000, REL);
        cyc("t3.idle", 4'b0000, REL);

        // Early drop by owner 0 while channel 2 waits.
        req = 4'b0101;
        for (int i = 0; i < 3; i++) cyc("t4.own0", 4'b0001, 4'hA);
        req = 4'b0100;
        cyc("t4.turn", 4'b0000, REL);
        cyc("t4.ch2", 4'b0100, 4'h2);
        chk("t4.owner", {2'b00, owner}, 4'h2);
        din[11:8] = 4'h6;
        #1;
        chk("t4.passthru", bus, 4'h6);

        // Asynchronous reset between edges while channel 2 drives.
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5.gnt", gnt, 4'b0000);
        chk("t5.busy", {3'b000, busy}, 4'h0);
        chk("t5.bus", bus, REL);
        chk("t5.owner", {2'b00, owner}, 4'h0);
        chk("t5.bus_q", bus_q, 4'h0);
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b0011;
        cyc("t5.first", 4'b0001, 4'hA);
        req = 4'b0000;
        cyc("t5.turn", 4'b0000, REL);
        cyc("t5.idle", 4'b0000, REL);
        chk("t5.idle_q", bus_q, KEEP ? 4'hA : REL);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
